// File: rtl/rf_fpga_pkg.sv
// Shared constants for the FPGA register-file controller: default parameters,
// key indices, the read-select mode enum and a counter-width helper.
package rf_fpga_pkg;

  localparam int DATA_W_DEF   = 32;
  localparam int SEL_W_DEF    = 5;
  localparam int NREAD_DEF    = 2;
  localparam int SWDAT_W_DEF  = 3;
  localparam int LED_W_DEF    = 4;
  localparam int DEB_CYC_DEF  = 500000;
  localparam int SCAN_DIV_DEF = 25000000;

  localparam int KEY_WR   = 0;
  localparam int KEY_MODE = 1;

  typedef enum logic {
    MODE_MANUAL = 1'b0,
    MODE_SCAN   = 1'b1
  } mode_t;

  // Bits needed for a counter that spans 0..n-1, never less than one bit.
  function automatic int cnt_w(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/rf_fpga_ctrl_key_debounce.sv
// Single-key conditioning: 2-flop synchroniser, stable-count debouncer and a
// one-cycle pulse on each debounced released->pressed transition.
// The key is active-low; every flop resets to the released state so a key
// held through reset has to be debounced from scratch.
module key_debounce
  import rf_fpga_pkg::*;
#(
  parameter int DEB_CYC = DEB_CYC_DEF
) (
  input  logic clk,
  input  logic rst,
  input  logic key_n,
  output logic press
);

  localparam int CW = cnt_w(DEB_CYC);
  localparam logic [CW-1:0] CNT_TC = CW'(DEB_CYC - 1);

  logic [1:0]    sync_q, sync_d;
  logic          deb_n_q, deb_n_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          press_q, press_d;

  // Count consecutive cycles where the synchronised key disagrees with the
  // debounced state; any agreement (a bounce back) restarts the count.
  always_comb begin
    sync_d  = {sync_q[0], key_n};
    deb_n_d = deb_n_q;
    cnt_d   = '0;
    press_d = 1'b0;
    if (sync_q[1] != deb_n_q) begin
      if (cnt_q == CNT_TC) begin
        deb_n_d = sync_q[1];
        press_d = ~sync_q[1];
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
  end

  // State registers, cleared to the released key state.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_q  <= 2'b11;
      deb_n_q <= 1'b1;
      cnt_q   <= '0;
      press_q <= 1'b0;
    end else begin
      sync_q  <= sync_d;
      deb_n_q <= deb_n_d;
      cnt_q   <= cnt_d;
      press_q <= press_d;
    end
  end

  assign press = press_q;

endmodule

// File: rtl/rf_fpga_ctrl.sv
// Switch/key front end for a register file on an FPGA board: registers the
// write/read selects and write data from switches, issues a single write
// strobe per debounced press of the write key and drives LEDs from read data.
// Optional read-select scan mode (key[1] toggles, port 0 steps through all
// registers) is built only when RF_FPGA_SCAN_EN is defined.
//
// mode        | meaning
// MODE_MANUAL | all read selects follow sw_rsel, scan pointer held at 0
// MODE_SCAN   | read port 0 follows scan_ptr, which steps every SCAN_DIV cycles
module rf_fpga_ctrl
  import rf_fpga_pkg::*;
#(
  parameter int DATA_W   = DATA_W_DEF,
  parameter int SEL_W    = SEL_W_DEF,
  parameter int NREAD    = NREAD_DEF,
  parameter int SWDAT_W  = SWDAT_W_DEF,
  parameter int LED_W    = LED_W_DEF,
  parameter int DEB_CYC  = DEB_CYC_DEF,
  parameter int SCAN_DIV = SCAN_DIV_DEF
) (
  input  logic                     CLK,
  input  logic                     RST,
  input  logic [1:0]               key_n,
  input  logic [SEL_W-1:0]         sw_wsel,
  input  logic [NREAD*SEL_W-1:0]   sw_rsel,
  input  logic [SWDAT_W-1:0]       sw_wdat,
  input  logic [NREAD*DATA_W-1:0]  rdat,
  output logic [SEL_W-1:0]         wsel,
  output logic [NREAD*SEL_W-1:0]   rsel,
  output logic [DATA_W-1:0]        wdat,
  output logic                     WEN,
  output logic [NREAD*LED_W-1:0]   led,
  output logic                     scan_mode,
  output logic [SEL_W-1:0]         scan_ptr
);

  logic wr_press;
  logic scan_sel;
  logic [SEL_W-1:0] scan_ptr_nxt;

  key_debounce #(.DEB_CYC(DEB_CYC)) u_key_wr (
    .clk   (CLK),
    .rst   (RST),
    .key_n (key_n[KEY_WR]),
    .press (wr_press)
  );

`ifdef RF_FPGA_SCAN_EN
  localparam int DW = cnt_w(SCAN_DIV);
  localparam logic [DW-1:0] DIV_TC = DW'(SCAN_DIV - 1);

  logic             mode_press;
  mode_t            mode_q, mode_d;
  logic [DW-1:0]    div_q, div_d;
  logic [SEL_W-1:0] scan_ptr_q, scan_ptr_d;

  key_debounce #(.DEB_CYC(DEB_CYC)) u_key_mode (
    .clk   (CLK),
    .rst   (RST),
    .key_n (key_n[KEY_MODE]),
    .press (mode_press)
  );

  // Mode toggle and scan divider; a toggle in either direction restarts the
  // divider and pointer so each scan pass begins at register 0.
  always_comb begin
    mode_d     = mode_q;
    div_d      = '0;
    scan_ptr_d = '0;
    if (mode_press) begin
      mode_d = (mode_q == MODE_SCAN) ? MODE_MANUAL : MODE_SCAN;
    end else if (mode_q == MODE_SCAN) begin
      if (div_q == DIV_TC) begin
        scan_ptr_d = scan_ptr_q + 1'b1;
      end else begin
        div_d      = div_q + 1'b1;
        scan_ptr_d = scan_ptr_q;
      end
    end
  end

  // Scan state registers.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      mode_q     <= MODE_MANUAL;
      div_q      <= '0;
      scan_ptr_q <= '0;
    end else begin
      mode_q     <= mode_d;
      div_q      <= div_d;
      scan_ptr_q <= scan_ptr_d;
    end
  end

  assign scan_sel     = (mode_d == MODE_SCAN);
  assign scan_ptr_nxt = scan_ptr_d;
  assign scan_mode    = (mode_q == MODE_SCAN);
  assign scan_ptr     = scan_ptr_q;
`else
  logic unused_key_mode;
  assign unused_key_mode = key_n[KEY_MODE];
  assign scan_sel        = 1'b0;
  assign scan_ptr_nxt    = '0;
  assign scan_mode       = 1'b0;
  assign scan_ptr        = '0;
`endif

  logic                   wen_q, wen_d;
  logic [SEL_W-1:0]       wsel_q, wsel_d;
  logic [NREAD*SEL_W-1:0] rsel_q, rsel_d;
  logic [DATA_W-1:0]      wdat_q, wdat_d;

  // Next values of the switch-driven outputs; rsel port 0 is registered from
  // the next scan pointer so it lines up with scan_ptr in the same cycle.
  always_comb begin
    wen_d                 = wr_press;
    wsel_d                = sw_wsel;
    wdat_d                = '0;
    wdat_d[SWDAT_W-1:0]   = sw_wdat;
    rsel_d                = sw_rsel;
    if (scan_sel) begin
      rsel_d[SEL_W-1:0] = scan_ptr_nxt;
    end
  end

  // Output registers.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      wen_q  <= 1'b0;
      wsel_q <= '0;
      rsel_q <= '0;
      wdat_q <= '0;
    end else begin
      wen_q  <= wen_d;
      wsel_q <= wsel_d;
      rsel_q <= rsel_d;
      wdat_q <= wdat_d;
    end
  end

  assign WEN  = wen_q;
  assign wsel = wsel_q;
  assign rsel = rsel_q;
  assign wdat = wdat_q;

  for (genvar i = 0; i < NREAD; i++) begin : g_led
    assign led[i*LED_W +: LED_W] = rdat[i*DATA_W +: LED_W];
  end

  logic unused_rdat;
  assign unused_rdat = ^rdat;

endmodule
